// File: rtl/rq_arb_pkg.sv
// Shared definitions for the two-requester PCIe RQ AXI-Stream arbiter.
//   AXIS_DATAW  : default AXIS data width in bits
//   RQ_USERW    : default RQ tuser width in bits
//   arb_state_e : arbiter FSM state encoding
package rq_arb_pkg;

    localparam int unsigned AXIS_DATAW = 512;
    localparam int unsigned RQ_USERW   = 183;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   s_t*_i          : upstream beat (data, keep, user, last, valid)
//   s_tready_o      : upstream may present a beat this cycle
//   m_t*_o          : registered downstream beat
//   m_tready_i      : downstream accepts the current beat
// Latency is one cycle; the register refills in the same cycle it drains, so throughput
// is one beat per cycle. Fields are frozen while m_tvalid_o=1 and m_tready_i=0.
module axis_reg_slice #(
    parameter int unsigned DataW = 512,
    parameter int unsigned KeepW = 16,
    parameter int unsigned UserW = 183
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DataW-1:0] s_tdata_i,
    input  logic [KeepW-1:0] s_tkeep_i,
    input  logic [UserW-1:0] s_tuser_i,
    input  logic             s_tlast_i,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    output logic [DataW-1:0] m_tdata_o,
    output logic [KeepW-1:0] m_tkeep_o,
    output logic [UserW-1:0] m_tuser_o,
    output logic             m_tlast_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i
);

    logic [DataW-1:0] data_q, data_d;
    logic [KeepW-1:0] keep_q, keep_d;
    logic [UserW-1:0] user_q, user_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    assign s_tready_o = !valid_q || m_tready_i;

    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        user_d  = user_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (s_tready_o) begin
            valid_d = s_tvalid_i;
            // Only capture payload on a real beat so idle cycles leave the bus quiet.
            if (s_tvalid_i) begin
                data_d = s_tdata_i;
                keep_d = s_tkeep_i;
                user_d = s_tuser_i;
                last_d = s_tlast_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            user_q  <= user_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_tdata_o  = data_q;
    assign m_tkeep_o  = keep_q;
    assign m_tuser_o  = user_q;
    assign m_tlast_o  = last_q;
    assign m_tvalid_o = valid_q;

endmodule

// File: rtl/rq_axis_arbiter.sv
// Packet-level round-robin arbiter merging two RQ AXI-Stream requesters onto one PCIe RQ port.
//   user_clk, user_reset_n : clock, asynchronous active-low reset
//   user_lnk_up            : new packets may only be granted while high
//   s_rq{0,1}_t*           : requester streams (tdata/tkeep/tuser/tlast/tvalid in, tready out)
//   m_axis_rq_t*           : registered merged stream towards the PCIe core
//   grant_id               : current or most recently granted requester
//   pkt_cnt{0,1}           : wrapping count of packets forwarded per requester
module rq_axis_arbiter #(
    parameter int unsigned AXIS_DATAW = rq_arb_pkg::AXIS_DATAW,
    parameter int unsigned RQ_USERW   = rq_arb_pkg::RQ_USERW,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     user_clk,
    input  logic                     user_reset_n,
    input  logic                     user_lnk_up,
    input  logic [AXIS_DATAW-1:0]    s_rq0_tdata,
    input  logic [AXIS_DATAW/32-1:0] s_rq0_tkeep,
    input  logic [RQ_USERW-1:0]      s_rq0_tuser,
    input  logic                     s_rq0_tlast,
    input  logic                     s_rq0_tvalid,
    output logic                     s_rq0_tready,
    input  logic [AXIS_DATAW-1:0]    s_rq1_tdata,
    input  logic [AXIS_DATAW/32-1:0] s_rq1_tkeep,
    input  logic [RQ_USERW-1:0]      s_rq1_tuser,
    input  logic                     s_rq1_tlast,
    input  logic                     s_rq1_tvalid,
    output logic                     s_rq1_tready,
    output logic [AXIS_DATAW-1:0]    m_axis_rq_tdata,
    output logic [AXIS_DATAW/32-1:0] m_axis_rq_tkeep,
    output logic [RQ_USERW-1:0]      m_axis_rq_tuser,
    output logic                     m_axis_rq_tlast,
    output logic                     m_axis_rq_tvalid,
    input  logic                     m_axis_rq_tready,
    output logic                     grant_id,
    output logic [CNT_W-1:0]         pkt_cnt0,
    output logic [CNT_W-1:0]         pkt_cnt1
);

    import rq_arb_pkg::*;

    localparam int unsigned KeepW = AXIS_DATAW / 32;

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

    logic                  out_ready;
    logic                  busy;
    logic                  accept;
    logic [AXIS_DATAW-1:0] sel_data;
    logic [KeepW-1:0]      sel_keep;
    logic [RQ_USERW-1:0]   sel_user;
    logic                  sel_last;
    logic                  sel_valid;

    assign busy = (state_q == StBusy);

    always_comb begin
        if (grant_q) begin
            sel_data  = s_rq1_tdata;
            sel_keep  = s_rq1_tkeep;
            sel_user  = s_rq1_tuser;
            sel_last  = s_rq1_tlast;
            sel_valid = s_rq1_tvalid;
        end else begin
            sel_data  = s_rq0_tdata;
            sel_keep  = s_rq0_tkeep;
            sel_user  = s_rq0_tuser;
            sel_last  = s_rq0_tlast;
            sel_valid = s_rq0_tvalid;
        end
    end

    assign accept = busy && sel_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;
        unique case (state_q)
            StIdle: begin
                if (user_lnk_up && (s_rq0_tvalid || s_rq1_tvalid)) begin
                    // On a tie the requester that did not go last wins; otherwise the lone one.
                    grant_d = (s_rq0_tvalid && s_rq1_tvalid) ? !last_grant_q : s_rq1_tvalid;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Link state is deliberately ignored here: a started packet always completes.
                if (accept && sel_last) begin
                    state_d      = StIdle;
                    last_grant_d = grant_q;
                    if (grant_q) begin
                        pkt_cnt1_d = pkt_cnt1_q + 1'b1;
                    end else begin
                        pkt_cnt0_d = pkt_cnt0_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
        end
    end

    assign s_rq0_tready = busy && !grant_q && out_ready;
    assign s_rq1_tready = busy && grant_q && out_ready;
    assign grant_id     = grant_q;
    assign pkt_cnt0     = pkt_cnt0_q;
    assign pkt_cnt1     = pkt_cnt1_q;

    axis_reg_slice #(
        .DataW (AXIS_DATAW),
        .KeepW (KeepW),
        .UserW (RQ_USERW)
    ) u_out_slice (
        .clk_i      (user_clk),
        .rst_ni     (user_reset_n),
        .s_tdata_i  (sel_data),
        .s_tkeep_i  (sel_keep),
        .s_tuser_i  (sel_user),
        .s_tlast_i  (sel_last),
        .s_tvalid_i (busy && sel_valid),
        .s_tready_o (out_ready),
        .m_tdata_o  (m_axis_rq_tdata),
        .m_tkeep_o  (m_axis_rq_tkeep),
        .m_tuser_o  (m_axis_rq_tuser),
        .m_tlast_o  (m_axis_rq_tlast),
        .m_tvalid_o (m_axis_rq_tvalid),
        .m_tready_i (m_axis_rq_tready)
    );

endmodule

// File: tb/tb_rq_axis_arbiter.sv
// Randomised and directed bench for rq_axis_arbiter against a packet-level reference model
// and an end-to-end per-requester scoreboard.
module tb_rq_axis_arbiter;

    localparam int DW = 64;
    localparam int KW = DW / 32;
    localparam int UW = 24;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          user_clk = 1'b0;
    logic          user_reset_n = 1'b0;
    logic          user_lnk_up = 1'b1;
    logic [DW-1:0] s_rq0_tdata, s_rq1_tdata;
    logic [KW-1:0] s_rq0_tkeep, s_rq1_tkeep;
    logic [UW-1:0] s_rq0_tuser, s_rq1_tuser;
    logic          s_rq0_tlast, s_rq1_tlast, s_rq0_tvalid, s_rq1_tvalid;
    logic          s_rq0_tready, s_rq1_tready;
    logic [DW-1:0] m_axis_rq_tdata;
    logic [KW-1:0] m_axis_rq_tkeep;
    logic [UW-1:0] m_axis_rq_tuser;
    logic          m_axis_rq_tlast, m_axis_rq_tvalid;
    logic          m_axis_rq_tready = 1'b1;
    logic          grant_id;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    rq_axis_arbiter #(
        .AXIS_DATAW (DW),
        .RQ_USERW   (UW),
        .CNT_W      (CW)
    ) dut (
        .user_clk         (user_clk),
        .user_reset_n     (user_reset_n),
        .user_lnk_up      (user_lnk_up),
        .s_rq0_tdata      (s_rq0_tdata),
        .s_rq0_tkeep      (s_rq0_tkeep),
        .s_rq0_tuser      (s_rq0_tuser),
        .s_rq0_tlast      (s_rq0_tlast),
        .s_rq0_tvalid     (s_rq0_tvalid),
        .s_rq0_tready     (s_rq0_tready),
        .s_rq1_tdata      (s_rq1_tdata),
        .s_rq1_tkeep      (s_rq1_tkeep),
        .s_rq1_tuser      (s_rq1_tuser),
        .s_rq1_tlast      (s_rq1_tlast),
        .s_rq1_tvalid     (s_rq1_tvalid),
        .s_rq1_tready     (s_rq1_tready),
        .m_axis_rq_tdata  (m_axis_rq_tdata),
        .m_axis_rq_tkeep  (m_axis_rq_tkeep),
        .m_axis_rq_tuser  (m_axis_rq_tuser),
        .m_axis_rq_tlast  (m_axis_rq_tlast),
        .m_axis_rq_tvalid (m_axis_rq_tvalid),
        .m_axis_rq_tready (m_axis_rq_tready),
        .grant_id         (grant_id),
        .pkt_cnt0         (pkt_cnt0),
        .pkt_cnt1         (pkt_cnt1)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Sources: packets waiting per requester; src_v marks the head beat as presented.
    beat_t src_q[2][$];
    bit    src_v[2];
    bit    acc[2];
    int    seq[2];
    int    vprob = 100;
    int    tr_prob = 100;
    bit    tr_pat[$];

    // Reference model: packet ownership, output register contents, counters.
    bit            md_busy;
    int            md_owner;
    int            md_last;
    bit            md_ovalid;
    beat_t         md_ob;
    logic [CW-1:0] md_cnt[2];
    logic          md_gid;

    // Scoreboard: beats accepted from each requester, awaiting the output.
    beat_t sent_q[2][$];
    int    out_owner = -1;
    beat_t out_log[$];
    int    pkt_order[$];
    int    n_out_pkts = 0;
    int    n_stalls = 0;
    bit    prev_stall;
    beat_t prev_beat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int budget);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no progress within %0d cycles, required completion", name, budget);
    endtask

    task automatic model_reset();
        md_busy   = 0;
        md_owner  = 0;
        md_last   = 1;
        md_ovalid = 0;
        md_ob     = '0;
        md_cnt[0] = '0;
        md_cnt[1] = '0;
        md_gid    = 1'b0;
        sent_q[0].delete();
        sent_q[1].delete();
        out_owner  = -1;
        prev_stall = 0;
        acc[0] = 0;
        acc[1] = 0;
    endtask

    task automatic add_pkt(input int r, input int len);
        beat_t      b;
        logic [63:0] rnd;
        for (int i = 0; i < len; i++) begin
            rnd    = {$urandom, $urandom};
            b.data = {r[0], seq[r][14:0], i[7:0], rnd[39:0]};
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (i == len - 1);
            src_q[r].push_back(b);
        end
        seq[r]++;
    endtask

    task automatic apply();
        beat_t b0, b1;
        b0 = '0;
        b1 = '0;
        if (src_v[0]) b0 = src_q[0][0];
        if (src_v[1]) b1 = src_q[1][0];
        {s_rq0_tdata, s_rq0_tkeep, s_rq0_tuser, s_rq0_tlast} = b0;
        {s_rq1_tdata, s_rq1_tkeep, s_rq1_tuser, s_rq1_tlast} = b1;
        s_rq0_tvalid = src_v[0];
        s_rq1_tvalid = src_v[1];
    endtask

    task automatic flush();
        for (int i = 0; i < 2; i++) begin
            src_q[i].delete();
            src_v[i] = 0;
            acc[i]   = 0;
        end
        apply();
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                src_v[i] = 0;
            end
            if (!src_v[i] && src_q[i].size() > 0 && $urandom_range(99) < vprob) src_v[i] = 1;
        end
        if (tr_pat.size() > 0) m_axis_rq_tready = tr_pat.pop_front();
        else m_axis_rq_tready = ($urandom_range(99) < tr_prob);
        apply();
    endtask

    // Compare the DUT with the model for the current cycle, then advance the model across
    // the coming clock edge.
    task automatic eval_cycle();
        logic  [1:0] v;
        logic        ordy;
        logic        take;
        beat_t       in_b[2];
        beat_t       cur;
        int          r;
        v   = {s_rq1_tvalid, s_rq0_tvalid};
        cur = {m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tuser, m_axis_rq_tlast};
        in_b[0] = {s_rq0_tdata, s_rq0_tkeep, s_rq0_tuser, s_rq0_tlast};
        in_b[1] = {s_rq1_tdata, s_rq1_tkeep, s_rq1_tuser, s_rq1_tlast};
        if (!user_reset_n) begin
            model_reset();
            chk("rst_tvalid", 128'(m_axis_rq_tvalid), 128'(0));
            chk("rst_tready", 128'({s_rq1_tready, s_rq0_tready}), 128'(0));
            return;
        end
        ordy = !md_ovalid || m_axis_rq_tready;
        chk("tready0", 128'(s_rq0_tready), 128'(md_busy && md_owner == 0 && ordy));
        chk("tready1", 128'(s_rq1_tready), 128'(md_busy && md_owner == 1 && ordy));
        chk("m_tvalid", 128'(m_axis_rq_tvalid), 128'(md_ovalid));
        if (md_ovalid) chk("m_beat", 128'(cur), 128'(md_ob));
        chk("grant_id", 128'(grant_id), 128'(md_gid));
        chk("pkt_cnt0", 128'(pkt_cnt0), 128'(md_cnt[0]));
        chk("pkt_cnt1", 128'(pkt_cnt1), 128'(md_cnt[1]));
        if (prev_stall) chk("stall_hold", 128'(cur), 128'(prev_beat));
        prev_stall = m_axis_rq_tvalid && !m_axis_rq_tready;
        prev_beat  = cur;
        if (prev_stall) n_stalls++;

        acc[0] = s_rq0_tvalid && s_rq0_tready;
        acc[1] = s_rq1_tvalid && s_rq1_tready;
        for (int i = 0; i < 2; i++) if (acc[i]) sent_q[i].push_back(in_b[i]);

        if (m_axis_rq_tvalid && m_axis_rq_tready) begin
            r = int'(cur.data[DW-1]);
            if (out_owner >= 0) chk("no_interleave", 128'(r), 128'(out_owner));
            chk("sb_avail", 128'(sent_q[r].size() != 0), 128'(1));
            if (sent_q[r].size() != 0) begin
                chk("sb_beat", 128'(cur), 128'(sent_q[r][0]));
                void'(sent_q[r].pop_front());
            end
            out_log.push_back(cur);
            if (cur.last) begin
                out_owner = -1;
                pkt_order.push_back(r);
                n_out_pkts++;
            end else begin
                out_owner = r;
            end
        end

        if (md_busy) begin
            take = v[md_owner] && ordy;
            if (ordy) begin
                md_ovalid = take;
                if (take) md_ob = in_b[md_owner];
            end
            if (take && in_b[md_owner].last) begin
                md_busy = 0;
                md_last = md_owner;
                md_cnt[md_owner] = md_cnt[md_owner] + 1'b1;
            end
        end else begin
            if (ordy) md_ovalid = 0;
            if (user_lnk_up && v != 2'b00) begin
                md_owner = (v == 2'b11) ? 1 - md_last : (v[1] ? 1 : 0);
                md_busy  = 1;
                md_gid   = md_owner[0];
            end
        end
    endtask

    task automatic step();
        @(negedge user_clk);
        eval_cycle();
        @(posedge user_clk);
        #1;
        drive();
    endtask

    task automatic reset_on();
        user_reset_n = 1'b0;
        flush();
        step();
        step();
        chk("rst_tdata", 128'(m_axis_rq_tdata), 128'(0));
        chk("rst_tkeep", 128'(m_axis_rq_tkeep), 128'(0));
        chk("rst_tuser", 128'(m_axis_rq_tuser), 128'(0));
        chk("rst_tlast", 128'(m_axis_rq_tlast), 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));
        chk("rst_cnts", 128'({pkt_cnt1, pkt_cnt0}), 128'(0));
        out_log.delete();
        pkt_order.delete();
        n_stalls = 0;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int k = 0;
        while (src_q[0].size() != 0 || src_q[1].size() != 0 || md_busy || md_ovalid) begin
            if (k >= budget) begin
                timeout_fail(name, budget);
                return;
            end
            step();
            k++;
        end
        step();
    endtask

    task automatic wait_out_beats(input string name, input int n, input int budget);
        int k = 0;
        while (out_log.size() < n) begin
            if (k >= budget) begin
                timeout_fail(name, budget);
                return;
            end
            step();
            k++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        model_reset();
        flush();

        // Basic single-requester 3-beat transfer.
        reset_on();
        user_reset_n = 1'b1;
        add_pkt(0, 3);
        run_until_idle("basic", 50);
        chk("basic_beats", 128'(out_log.size()), 128'(3));
        if (out_log.size() == 3)
            chk("basic_last", 128'({out_log[0].last, out_log[1].last, out_log[2].last}),
                128'(3'b001));
        chk("basic_cnt0", 128'(pkt_cnt0), 128'(1));

        // Tie-break and alternation with both requesters continuously valid from reset.
        reset_on();
        for (int p = 0; p < 2; p++) begin
            add_pkt(0, 2);
            add_pkt(1, 2);
        end
        user_reset_n = 1'b1;
        run_until_idle("alternate", 100);
        chk("alt_beats", 128'(out_log.size()), 128'(8));
        if (pkt_order.size() == 4)
            chk("alt_order", 128'({pkt_order[0][1:0], pkt_order[1][1:0], pkt_order[2][1:0],
                                   pkt_order[3][1:0]}), 128'(8'b00_01_00_01));
        else chk("alt_npkts", 128'(pkt_order.size()), 128'(4));

        // Backpressure: first beat leaves with ready=1, then two stalled cycles.
        reset_on();
        user_reset_n = 1'b1;
        tr_pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        add_pkt(0, 4);
        run_until_idle("backpressure", 60);
        chk("bp_beats", 128'(out_log.size()), 128'(4));
        chk("bp_stalls", 128'(n_stalls), 128'(2));
        for (int i = 0; i < out_log.size(); i++)
            chk("bp_order", 128'(out_log[i].data[47:40]), 128'(i));

        // Link drops mid-packet from requester 1.
        reset_on();
        user_reset_n = 1'b1;
        add_pkt(1, 4);
        wait_out_beats("lnk_start", 1, 30);
        user_lnk_up = 1'b0;
        add_pkt(0, 2);
        for (int i = 0; i < 15; i++) step();
        chk("lnk_cnt1", 128'(pkt_cnt1), 128'(1));
        chk("lnk_cnt0_held", 128'(pkt_cnt0), 128'(0));
        chk("lnk_beats", 128'(out_log.size()), 128'(4));
        user_lnk_up = 1'b1;
        run_until_idle("lnk_resume", 50);
        chk("lnk_cnt0", 128'(pkt_cnt0), 128'(1));

        // Counter wrap: 17 single-beat packets with a 4-bit counter.
        reset_on();
        user_reset_n = 1'b1;
        for (int i = 0; i < 17; i++) add_pkt(0, 1);
        run_until_idle("wrap", 200);
        chk("wrap_cnt0", 128'(pkt_cnt0), 128'(1));

        // Reset while beat 2 of 4 sits in the output register.
        reset_on();
        user_reset_n = 1'b1;
        add_pkt(0, 4);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            found = m_axis_rq_tvalid && (m_axis_rq_tdata[47:40] == 8'd1);
        end
        if (!found) timeout_fail("rst_mid_find", 30);
        #2;
        user_reset_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 128'(m_axis_rq_tvalid), 128'(0));
        chk("rst_mid_tready", 128'(s_rq0_tready), 128'(0));
        flush();
        step();
        step();
        out_log.delete();
        pkt_order.delete();
        add_pkt(0, 1);
        add_pkt(1, 1);
        user_reset_n = 1'b1;
        run_until_idle("rst_mid_after", 40);
        chk("rst_mid_npkts", 128'(pkt_order.size()), 128'(2));
        if (pkt_order.size() != 0) chk("rst_mid_first", 128'(pkt_order[0]), 128'(0));

        // Randomised traffic with link flaps and random backpressure.
        reset_on();
        user_reset_n = 1'b1;
        n_out_pkts = 0;
        tr_prob = 60;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) vprob = 30 + $urandom_range(70);
            if (c % 20 == 0) user_lnk_up = ($urandom_range(99) < 85);
            if ($urandom_range(99) < 30) begin
                int r;
                r = $urandom_range(1);
                if (src_q[r].size() < 12) add_pkt(r, 1 + $urandom_range(4));
            end
            step();
        end
        user_lnk_up = 1'b1;
        vprob = 100;
        tr_prob = 100;
        run_until_idle("rand_drain", 2000);
        chk("rand_sb_empty", 128'(sent_q[0].size() + sent_q[1].size()), 128'(0));
        chk("rand_activity", 128'(n_out_pkts > 20), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
